// File: rtl/dcp_pkg.sv
// Shared constants and state encoding for the debug-unit scan/print path.
package dcp_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_SP = 8'h20;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_PROC = 3'd2;
   localparam logic [2:0] ST_ECHO = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_WAIT = ST_WAIT,
      S_PROC = ST_PROC,
      S_ECHO = ST_ECHO,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/hex_nibble.sv
// Combinational ASCII-to-hex decoder: 0-9, a-f, A-F map to a nibble and set is_hex.
module hex_nibble (
   input  logic [7:0] ascii,
   output logic [3:0] nib,
   output logic       is_hex
);

   // Decode one character; letters land on 10..15 because their low nibble is 1..6.
   always_comb begin
      nib    = 4'h0;
      is_hex = 1'b0;
      if (ascii >= 8'h30 && ascii <= 8'h39) begin
         is_hex = 1'b1;
         nib    = ascii[3:0];
      end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                   (ascii >= 8'h61 && ascii <= 8'h66)) begin
         is_hex = 1'b1;
         nib    = ascii[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/scan_rx.sv
// Receive-side scanner for the debug unit: returns one raw character or a
// hex number terminated by Enter/Space, echoing digits and backspaces.
//
// Handshakes: rx and tx channels use valid/ready. A byte moves on a rising
// clk edge where valid and ready are both 1; the sender holds valid and data
// stable until that edge. req_rx is a level sampled only in IDLE, and ack_rx
// is a one-cycle pulse during which din_rx already holds the new result.
module scan_rx
   import dcp_pkg::*;
#(
   parameter bit ECHO       = 1'b1,
   parameter int MAX_DIGITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_rx,
   input  logic        type_rx,
   output logic        ack_rx,
   output logic [31:0] din_rx,
   input  logic        vld_rx,
   output logic        rdy_rx,
   input  logic [7:0]  d_rx,
   output logic        vld_tx,
   input  logic        rdy_tx,
   output logic [7:0]  d_tx,
   output state_t      dbg_state
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   state_t        state, state_nx;
   logic          typ_q;
   logic [7:0]    byte_q;
   logic [31:0]   acc;
   logic [CW-1:0] cnt;
   logic [31:0]   din_q;

   logic [3:0]    nib;
   logic          is_hex;
   logic          do_push;
   logic          do_pop;
   logic          do_load;

   hex_nibble u_hex (
      .ascii  (byte_q),
      .nib    (nib),
      .is_hex (is_hex)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state decode plus accumulator/result strobes.
   always_comb begin
      state_nx = state;
      do_push  = 1'b0;
      do_pop   = 1'b0;
      do_load  = 1'b0;
      case (state)
         S_IDLE: if (req_rx) state_nx = S_WAIT;
         S_WAIT: if (vld_rx) state_nx = S_PROC;
         S_PROC: begin
            if (!typ_q) begin
               state_nx = ECHO ? S_ECHO : S_DONE;
            end else if (is_hex) begin
               state_nx = S_WAIT;
               if (cnt < CW'(MAX_DIGITS)) begin
                  do_push  = 1'b1;
                  state_nx = ECHO ? S_ECHO : S_WAIT;
               end
            end else if (byte_q == ASCII_BS) begin
               state_nx = S_WAIT;
               if (cnt != '0) begin
                  do_pop   = 1'b1;
                  state_nx = ECHO ? S_ECHO : S_WAIT;
               end
            end else if (byte_q == ASCII_CR || byte_q == ASCII_SP) begin
               state_nx = S_DONE;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_ECHO: if (rdy_tx) state_nx = typ_q ? S_WAIT : S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      // The result is captured on the way into DONE so it is valid with ack.
      if (state_nx == S_DONE && state != S_DONE) do_load = 1'b1;
   end

   // Request type, received byte, accumulator, digit count and result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         typ_q  <= 1'b0;
         byte_q <= 8'h00;
         acc    <= 32'h0;
         cnt    <= '0;
         din_q  <= 32'h0;
      end else begin
         if (state == S_IDLE && req_rx) begin
            typ_q <= type_rx;
            acc   <= 32'h0;
            cnt   <= '0;
         end
         if (state == S_WAIT && vld_rx) byte_q <= d_rx;
         if (do_push) begin
            acc <= {acc[27:0], nib};
            cnt <= cnt + CW'(1);
         end else if (do_pop) begin
            acc <= acc >> 4;
            cnt <= cnt - CW'(1);
         end
         if (do_load) din_q <= typ_q ? acc : {24'h0, byte_q};
      end
   end

   assign rdy_rx    = (state == S_WAIT);
   assign vld_tx    = (state == S_ECHO);
   assign d_tx      = (state == S_ECHO) ? byte_q : 8'h00;
   assign ack_rx    = (state == S_DONE);
   assign din_rx    = din_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_scan_rx.sv
// Self-checking bench for scan_rx: echo bytes and results are predicted into
// queues as stimulus is driven and compared when the DUT presents them.
module tb_scan_rx;

   logic        clk;
   logic        rst;
   logic        req_rx;
   logic        type_rx;
   logic        ack_rx;
   logic [31:0] din_rx;
   logic        vld_rx;
   logic        rdy_rx;
   logic [7:0]  d_rx;
   logic        vld_tx;
   logic        rdy_tx;
   logic [7:0]  d_tx;
   dcp_pkg::state_t dbg_state;

   logic [7:0]  echo_q[$];
   logic [31:0] exp_q[$];

   int total = 0;
   int bad   = 0;
   int ack_seen = 0;
   int acks_expected = 0;
   bit rand_tx = 0;

   scan_rx #(.ECHO(1'b1), .MAX_DIGITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_rx    (req_rx),
      .type_rx   (type_rx),
      .ack_rx    (ack_rx),
      .din_rx    (din_rx),
      .vld_rx    (vld_rx),
      .rdy_rx    (rdy_rx),
      .d_rx      (d_rx),
      .vld_tx    (vld_tx),
      .rdy_tx    (rdy_tx),
      .d_tx      (d_tx),
      .dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // monitor: echo transfers and result acks, sampled on the falling edge
   always @(negedge clk) begin
      if (vld_tx && rdy_tx) begin
         if (echo_q.size() == 0) chk("echo_unexpected", 32'(echo_q.size()), 32'd1);
         else chk("echo", {24'h0, d_tx}, {24'h0, echo_q.pop_front()});
      end
      if (ack_rx) begin
         ack_seen++;
         if (exp_q.size() == 0) chk("ack_unexpected", 32'(exp_q.size()), 32'd1);
         else chk("din", din_rx, exp_q.pop_front());
      end
   end

   // optional random backpressure on the echo channel
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_tx) rdy_tx = 1'($urandom_range(0, 1));
      end
   end

   task automatic start(input logic t);
      req_rx  = 1'b1;
      type_rx = t;
      @(posedge clk); #1;
      req_rx  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got = 0;
      vld_rx = 1'b1;
      d_rx   = b;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge clk);
         if (rdy_rx) begin
            @(posedge clk); #1;
            got = 1;
         end
      end
      vld_rx = 1'b0;
      if (!got) chk("rx_accept_timeout", 32'(got), 32'd1);
   endtask

   task automatic send_echoed(input logic [7:0] b);
      echo_q.push_back(b);
      send_byte(b);
   endtask

   task automatic wait_ack(input int n);
      int i = 0;
      while (ack_seen < n && i < 1000) begin
         @(negedge clk);
         i++;
      end
      if (ack_seen < n) chk("ack_timeout", 32'(ack_seen), 32'(n));
   endtask

   task automatic wait_vld_tx();
      int i = 0;
      while (!vld_tx && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (!vld_tx) chk("vld_tx_timeout", 32'(vld_tx), 32'd1);
   endtask

   function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
      if (n < 4'd10) return 8'h30 + 8'(n);
      return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
   endfunction

   initial begin
      logic [31:0] m_acc;
      int          m_cnt;
      int          nd;
      logic [3:0]  nb;
      logic [7:0]  ch;

      rst = 1'b0; req_rx = 1'b0; type_rx = 1'b0;
      vld_rx = 1'b0; d_rx = 8'h00; rdy_tx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack_rx), 32'd0);
      chk("rst_din", din_rx, 32'h0);
      chk("rst_rdy_rx", 32'(rdy_rx), 32'd0);
      chk("rst_vld_tx", 32'(vld_tx), 32'd0);
      chk("rst_d_tx", {24'h0, d_tx}, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // single character, byte offered together with the request
      req_rx = 1'b1; type_rx = 1'b0; vld_rx = 1'b1; d_rx = 8'h41;
      @(negedge clk);
      chk("rdy_in_idle", 32'(rdy_rx), 32'd0);
      @(posedge clk); #1;
      req_rx = 1'b0;
      exp_q.push_back(32'h41); acks_expected++;
      send_echoed(8'h41);
      wait_ack(acks_expected);

      // "1A2b" CR, plus terminator-to-ack latency
      start(1'b1);
      send_echoed("1"); send_echoed("A"); send_echoed("2"); send_echoed("b");
      exp_q.push_back(32'h0000_1A2B); acks_expected++;
      send_byte(8'h0D);
      @(negedge clk);
      chk("lat_n1", 32'(ack_rx), 32'd0);
      @(negedge clk);
      chk("lat_n2", 32'(ack_rx), 32'd1);
      wait_ack(acks_expected);

      // backspace editing, Space terminator
      start(1'b1);
      send_echoed("1"); send_echoed("2"); send_echoed("3");
      send_echoed(8'h08); send_echoed("4");
      exp_q.push_back(32'h124); acks_expected++;
      send_byte(8'h20);
      wait_ack(acks_expected);

      // overflow digit discarded
      start(1'b1);
      send_echoed("D"); send_echoed("E"); send_echoed("A"); send_echoed("D");
      send_echoed("B"); send_echoed("E"); send_echoed("E"); send_echoed("F");
      send_byte("9");
      exp_q.push_back(32'hDEAD_BEEF); acks_expected++;
      send_byte(8'h0D);
      wait_ack(acks_expected);

      // junk byte and backspace with no digits are ignored
      start(1'b1);
      send_byte("G");
      send_byte(8'h08);
      exp_q.push_back(32'h0); acks_expected++;
      send_byte(8'h0D);
      wait_ack(acks_expected);

      // echo held off by rdy_tx low
      rdy_tx = 1'b0;
      start(1'b1);
      send_byte("3");
      wait_vld_tx();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_vld_tx", 32'(vld_tx), 32'd1);
         chk("hold_d_tx", {24'h0, d_tx}, 32'h33);
         chk("hold_rdy_rx", 32'(rdy_rx), 32'd0);
      end
      echo_q.push_back("3");
      @(posedge clk); #1;
      rdy_tx = 1'b1;
      exp_q.push_back(32'h3); acks_expected++;
      send_byte(8'h0D);
      wait_ack(acks_expected);

      // reset while an echo is pending: everything drops at once
      rdy_tx = 1'b0;
      start(1'b1);
      send_byte("5");
      wait_vld_tx();
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("arst_vld_tx", 32'(vld_tx), 32'd0);
      chk("arst_d_tx", {24'h0, d_tx}, 32'h0);
      chk("arst_din", din_rx, 32'h0);
      chk("arst_ack", 32'(ack_rx), 32'd0);
      chk("arst_rdy_rx", 32'(rdy_rx), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; rdy_tx = 1'b1;
      @(posedge clk); #1;
      start(1'b1);
      send_echoed("7");
      exp_q.push_back(32'h7); acks_expected++;
      send_byte(8'h0D);
      wait_ack(acks_expected);

      // random numbers with random case, edits, junk and echo backpressure
      rand_tx = 1;
      for (int t = 0; t < 8; t++) begin
         m_acc = 32'h0; m_cnt = 0;
         start(1'b1);
         nd = $urandom_range(1, 11);
         for (int k = 0; k < nd; k++) begin
            case ($urandom_range(0, 5))
               0: begin
                  if (m_cnt > 0) begin
                     m_acc = m_acc >> 4; m_cnt--;
                     send_echoed(8'h08);
                  end else begin
                     send_byte(8'h08);
                  end
               end
               1: send_byte("x");
               default: begin
                  nb = 4'($urandom_range(0, 15));
                  ch = hex_char(nb, 1'($urandom_range(0, 1)));
                  if (m_cnt < 8) begin
                     m_acc = {m_acc[27:0], nb}; m_cnt++;
                     send_echoed(ch);
                  end else begin
                     send_byte(ch);
                  end
               end
            endcase
         end
         exp_q.push_back(m_acc); acks_expected++;
         send_byte($urandom_range(0, 1) ? 8'h0D : 8'h20);
         wait_ack(acks_expected);
      end
      @(negedge clk);
      rand_tx = 0;
      rdy_tx = 1'b1;

      repeat (5) @(negedge clk);
      chk("echo_left", 32'(echo_q.size()), 32'd0);
      chk("result_left", 32'(exp_q.size()), 32'd0);
      chk("ack_count", 32'(ack_seen), 32'(acks_expected));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
